// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM state type for the register-file dumper.
// The CSUM state exists only when DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SEND   = 3'd2,
`ifdef DUMP_CHECKSUM_EN
        CSUM   = 3'd3,
`endif
        FINISH = 3'd4
    } dump_state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// Walks registers 0..NUM_REGS-1 and streams each byte over a valid/ready link.
// Define DUMP_CHECKSUM_EN to append a mod-2^DATA_W checksum byte after the registers.
module reg_file_dumper
    import reg_dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              xfer;
    logic              last;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    assign xfer = tx_valid && tx_ready;
    assign last = (idx == ADDR_W'(NUM_REGS - 1));

    // NOTE: state flops use non-blocking assignments and reset asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = SEND;
            SEND: begin
                if (xfer) begin
`ifdef DUMP_CHECKSUM_EN
                    state_nxt = last ? CSUM : FETCH;
`else
                    state_nxt = last ? FINISH : FETCH;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM:    if (xfer) state_nxt = FINISH;
`endif
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte is captured at the FETCH edge, so later register writes do not leak into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
`ifdef DUMP_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                FETCH: begin
                    tx_data  <= rf_data;
                    tx_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    checksum <= checksum + rf_data;
`endif
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
`ifdef DUMP_CHECKSUM_EN
                            tx_data  <= checksum;
                            tx_valid <= 1'b1;
`else
                            tx_valid <= 1'b0;
`endif
                        end else begin
                            tx_valid <= 1'b0;
                            idx      <= idx + ADDR_W'(1);
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    if (xfer) tx_valid <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign rf_addr = (state == FETCH || state == SEND) ? idx : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper with a stream-level reference model.
// Honours DUMP_CHECKSUM_EN to expect the trailing checksum byte.
module tb_reg_file_dumper;
    import reg_dump_pkg::*;

`ifdef DUMP_CHECKSUM_EN
    localparam int TOTAL = NUM_REGS + 1;
`else
    localparam int TOTAL = NUM_REGS;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              tx_ready = 1'b0;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] ram [NUM_REGS];
    assign rf_data = ram[rf_addr];

    always #5 clk = ~clk;

    reg_file_dumper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: which bytes the stream must carry, and when DONE/BUSY apply.
    int                cyc = 0;
    logic [DATA_W-1:0] exp_reg [NUM_REGS];
    bit                m_active = 1'b0;
    bit                m_done = 1'b0;
    int                m_sent = 0;
    logic [DATA_W-1:0] m_sum = '0;
    int                start_edge = 0;
    int                xfer_rel [TOTAL];
    logic [DATA_W-1:0] xfer_data [TOTAL];
    int                done_rel = -1;
    int                done_count = 0;
    bit                hold_prev = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (!rst_n) begin
            check("rst_tx_valid", 32'(tx_valid), 32'd0);
            check("rst_tx_data", 32'(tx_data), 32'd0);
            check("rst_rf_addr", 32'(rf_addr), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_sent    = 0;
            m_sum     = '0;
            hold_prev = 1'b0;
        end else begin
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_done));
            if (m_done) begin
                done_count++;
                done_rel = cyc - start_edge;
            end
            if (!m_active) begin
                check("idle_tx_valid", 32'(tx_valid), 32'd0);
                check("idle_rf_addr", 32'(rf_addr), 32'd0);
            end
            if (hold_prev) begin
                check("hold_tx_valid", 32'(tx_valid), 32'd1);
                check("hold_tx_data", 32'(tx_data), 32'(prev_data));
                check("hold_rf_addr", 32'(rf_addr), 32'(prev_addr));
            end
            hold_prev = tx_valid && !tx_ready;
            prev_data = tx_data;
            prev_addr = rf_addr;

            if (m_done) begin
                m_done   = 1'b0;
                m_active = 1'b0;
            end else if (m_active && tx_valid && tx_ready) begin
                check("byte_count_in_range", 32'(m_sent < TOTAL), 32'd1);
                if (m_sent < TOTAL) begin
                    if (m_sent < NUM_REGS) begin
                        e     = exp_reg[m_sent];
                        m_sum = m_sum + e;
                        check($sformatf("rf_addr_byte%0d", m_sent), 32'(rf_addr), 32'(m_sent));
                    end else begin
                        e = m_sum;
                    end
                    check($sformatf("tx_data_byte%0d", m_sent), 32'(tx_data), 32'(e));
                    xfer_rel[m_sent]  = cyc + 1 - start_edge;
                    xfer_data[m_sent] = tx_data;
                    m_sent++;
                    if (m_sent == TOTAL) m_done = 1'b1;
                end
            end else if (!m_active && start) begin
                m_active   = 1'b1;
                m_sent     = 0;
                m_sum      = '0;
                start_edge = cyc + 1;
            end
        end
    end

    task automatic do_start();
        for (int i = 0; i < NUM_REGS; i++) exp_reg[i] = ram[i];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic write_reg(input int j, input logic [DATA_W-1:0] v);
        ram[j] = v;
        if (!m_active || j > m_sent) exp_reg[j] = v;
    endtask

    task automatic wait_sent(input int n, input bit need_valid, input string name);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (m_sent == n && (!need_valid || tx_valid)) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int prev;
        prev = done_count;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done_count > prev) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) ram[i] = DATA_W'(3 * i + 1);
        for (int i = 0; i < NUM_REGS; i++) exp_reg[i] = ram[i];

        #1 rst_n = 1'b0;
        #2;
        check("por_tx_valid", 32'(tx_valid), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Full dump with the link always ready.
        do_start();
        wait_done("timeout_dump1");
        check("d1_byte0_edge", 32'(xfer_rel[0]), 32'd2);
        check("d1_byte0", 32'(xfer_data[0]), 32'h01);
        check("d1_byte1", 32'(xfer_data[1]), 32'h04);
        check("d1_byte31_edge", 32'(xfer_rel[31]), 32'd64);
        check("d1_byte31", 32'(xfer_data[31]), 32'h5E);
`ifdef DUMP_CHECKSUM_EN
        check("d1_csum_edge", 32'(xfer_rel[32]), 32'd65);
        check("d1_csum", 32'(xfer_data[32]), 32'hF0);
        check("d1_done_edge", 32'(done_rel), 32'd65);
`else
        check("d1_done_edge", 32'(done_rel), 32'd64);
`endif
        check("d1_done_count", 32'(done_count), 32'd1);
        repeat (3) @(posedge clk);

        // Backpressure for 5 cycles while byte 7 is presented.
        do_start();
        wait_sent(7, 1'b1, "timeout_byte7_valid");
        tx_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_tx_valid", 32'(tx_valid), 32'd1);
            check("bp_tx_data", 32'(tx_data), 32'h16);
            check("bp_rf_addr", 32'(rf_addr), 32'd7);
        end
        tx_ready = 1'b1;
        wait_done("timeout_dump2");
        check("bp_byte7_edge", 32'(xfer_rel[7]), 32'd21);
        check("bp_byte8", 32'(xfer_data[8]), 32'h19);
        check("bp_byte31_edge", 32'(xfer_rel[31]), 32'd69);
        check("bp_done_count", 32'(done_count), 32'd2);
        repeat (3) @(posedge clk);

        // START during SEND and during FINISH must be ignored.
        do_start();
        wait_sent(3, 1'b1, "timeout_byte3_valid");
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
        end
        check("finish_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("ignored_start_done_count", 32'(done_count), 32'd3);
        check("ignored_start_busy", 32'(busy), 32'd0);

        // Reset mid-dump after byte 10 transfers aborts without DONE.
        do_start();
        wait_sent(11, 1'b0, "timeout_byte10");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_rf_addr", 32'(rf_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_count), 32'd3);
        do_start();
        wait_done("timeout_dump_after_rst");
        check("restart_byte0", 32'(xfer_data[0]), 32'h01);
        check("restart_done_count", 32'(done_count), 32'd4);
        repeat (3) @(posedge clk);

        // Writes behind and ahead of the read pointer.
        do_start();
        wait_sent(6, 1'b0, "timeout_byte5");
        write_reg(5, 8'hAA);
        write_reg(20, 8'hBB);
        wait_done("timeout_dump_writes");
        check("wr_byte5_old", 32'(xfer_data[5]), 32'h10);
        check("wr_byte20_new", 32'(xfer_data[20]), 32'hBB);
`ifdef DUMP_CHECKSUM_EN
        check("wr_csum", 32'(xfer_data[32]), 32'h6E);
`endif
        check("wr_done_count", 32'(done_count), 32'd5);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_dumper.md
# reg_file_dumper

Sequential reader that walks the 32×8 CPU register file from register 0 to 31 and streams each byte out over a valid/ready byte interface, for debug dump over a serial or port link. It sits beside the register file, drives one of its asynchronous read addresses, and hands bytes to a downstream transmitter (UART TX or output-port bridge). It does not write the register file.

## Interface
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1)
- DATA_W, 8, register and stream byte width
- ADDR_W, 5, register address width (clog2 of NUM_REGS)

- CLK  input  1  single clock; all state updates on posedge
- RST_N  input  1  reset, asynchronous and active-low
- START  input  1  begin dump; sampled only in IDLE
- RF_ADDR  output  ADDR_W  read address to register file
- RF_DATA  input  DATA_W  combinational read data for RF_ADDR
- TX_DATA  output  DATA_W  stream byte, registered
- TX_VALID  output  1  TX_DATA valid, registered
- TX_READY  input  1  downstream accepts; transfer when TX_VALID and TX_READY at posedge
- BUSY  output  1  high in any state except IDLE
- DONE  output  1  one-cycle pulse after the final transfer

## Operation
- States: IDLE, FETCH, SEND, CSUM (only when checksum compiled in), FINISH.
- IDLE: RF_ADDR=0, TX_VALID=0. START=1 at posedge -> FETCH, idx=0, checksum=0.
- FETCH: RF_ADDR=idx. At posedge: TX_DATA<=RF_DATA, TX_VALID<=1, checksum<=checksum+RF_DATA (mod 2^DATA_W) -> SEND.
- SEND: TX_DATA, TX_VALID, and RF_ADDR=idx held stable until transfer. On transfer: TX_VALID<=0; if idx==NUM_REGS-1 -> CSUM (checksum build) or FINISH; else idx<=idx+1 -> FETCH.
- CSUM: TX_DATA=checksum, TX_VALID=1 until transfer -> FINISH.
- FINISH: DONE=1 for exactly this cycle -> IDLE unconditionally.
- Byte sent is the register value during its FETCH cycle; later writes to that register are not reflected. Writes to not-yet-fetched registers are reflected.
- START while BUSY (including in FINISH) is ignored; no queueing.
- idx never wraps: the terminal compare stops at NUM_REGS-1.

## Timing
- Reset (asynchronous, any state): state=IDLE, idx=0, checksum=0, RF_ADDR=0, TX_DATA=0, TX_VALID=0, BUSY=0, DONE=0. Reset mid-dump aborts with no DONE; the next START restarts at register 0.
- START sampled at edge 0 -> FETCH cycle 1 -> TX_VALID high from edge 1.
- With TX_READY held high, byte i transfers at edge 2i+2. Two cycles per byte.
- No checksum: last transfer at edge 64; DONE high between edges 64 and 65; IDLE after edge 65.
- Checksum: checksum byte valid after edge 64, transfers at edge 65 if ready; DONE between edges 65 and 66.
- TX_VALID never deasserts without a transfer. TX_DATA never changes while TX_VALID=1 and TX_READY=0.
- BUSY and DONE decode from the state register and are glitch-free.

## Configuration
- DUMP_CHECKSUM_EN defined: CSUM state exists. After the 32 register bytes, one extra byte is sent: the sum mod 256 of the bytes sent.
- Undefined: no CSUM state and no checksum register. Exactly NUM_REGS bytes are sent, then FINISH.

## Structure
- Shared package reg_dump_pkg: state enum typedef (dump_state_t), NUM_REGS/DATA_W/ADDR_W default constants.
- Single module. No sub-module; the checksum accumulator is an inline register under the macro.

## Test plan
- Reset: assert RST_N=0 mid-cycle -> all outputs 0 immediately, state IDLE, BUSY=0.
- Preload ram[i]=3i+1, TX_READY=1, pulse START at edge 0 -> bytes 0x01,0x04,…,0x5E in order at edges 2,4,…,64; DONE only between edges 64 and 65.
- Same with DUMP_CHECKSUM_EN -> 33rd byte 0xF0 at edge 65; DONE only between edges 65 and 66.
- Backpressure: drop TX_READY for 5 cycles while byte 7 is valid -> TX_VALID=1, TX_DATA=0x16, RF_ADDR=7 all stable; resumes with byte 8=0x19.
- START pulsed during SEND and during FINISH -> ignored; exactly one dump and one DONE.
- RST_N low after byte 10 transfers -> no DONE. New START -> dump restarts with 0x01 from register 0.
- Write ram[5]=0xAA after register 5's FETCH -> byte 5 stays 0x10. Write ram[20]=0xBB before its FETCH -> byte 20 is 0xBB.
